pulse_burst_gen: RTL and testbench

- Inverse of the button conditioning path: turns a one-clock event pulse into a timed, human-visible output.
- On a trigger it drives NBURST high pulses, each ON_TICKS long, separated by OFF_TICKS low gaps.
- Sits between the alarm/event logic and an LED or buzzer pin of the post-op monitor.
- Reports busy while a burst runs and a one-clock done pulse when it finishes.

---
 rtl/pulse_burst_gen_pkg.sv | 17 +
 rtl/pulse_burst_gen_tick_timer.sv | 31 +++
 rtl/pulse_burst_gen.sv | 109 ++++++++++
 tb/tb_pulse_burst_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pulse_burst_gen_pkg.sv
// Shared definitions for the pulse burst generator: state encoding and default timing.
// Default tick constants assume a 100 MHz clock (500_000 cycles = 5 ms).
package pulse_burst_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ON   = 2'b01,
        OFF  = 2'b10
    } state_t;

    localparam int DEF_NBIT      = 19;
    localparam int DEF_ON_TICKS  = 500_000;
    localparam int DEF_OFF_TICKS = 500_000;
    localparam int DEF_NBURST    = 3;
    localparam int DEF_CBIT      = 2;

endpackage

// File: rtl/pulse_burst_gen_tick_timer.sv
// Clearable enable counter that flags when the count equals the supplied terminal value.
// The terminal value is an input so one timer can serve both the ON and OFF phases.
module tick_timer
    import pulse_burst_gen_pkg::*;
#(
    parameter int Nbit = DEF_NBIT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [Nbit-1:0] term,
    output logic            tc
);

    logic [Nbit-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + Nbit'(1);
        end
    end

    assign tc = (count == term);

endmodule

// File: rtl/pulse_burst_gen.sv
// Turns a one-clock trigger into NBURST high pulses of ON_TICKS separated by OFF_TICKS gaps.
// Define PULSE_BURST_RETRIGGER_EN to let a trigger during a burst restart it from the first pulse.
module pulse_burst_gen
    import pulse_burst_gen_pkg::*;
#(
    parameter int Nbit      = DEF_NBIT,
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS,
    parameter int NBURST    = DEF_NBURST,
    parameter int Cbit      = DEF_CBIT
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic out,
    output logic busy,
    output logic done
);

    localparam logic [Nbit-1:0] ON_TERM    = Nbit'(ON_TICKS - 1);
    localparam logic [Nbit-1:0] OFF_TERM   = Nbit'(OFF_TICKS - 1);
    localparam logic [Cbit-1:0] LAST_BURST = Cbit'(NBURST - 1);

    state_t          state, state_nxt;
    logic [Cbit-1:0] burst, burst_nxt;
    logic            tick_clr, tick_tc, done_nxt;
    logic [Nbit-1:0] term;
    logic            tick_en;

    assign term    = (state == OFF) ? OFF_TERM : ON_TERM;
    assign tick_en = (state != IDLE);

    tick_timer #(.Nbit(Nbit)) u_tick_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .en   (tick_en),
        .term (term),
        .tc   (tick_tc)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        burst_nxt = burst;
        tick_clr  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (trig) begin
                    state_nxt = ON;
                    burst_nxt = '0;
                    tick_clr  = 1'b1;
                end
            end
            ON: begin
                if (tick_tc) begin
                    tick_clr = 1'b1;
                    if (burst == LAST_BURST) begin
                        state_nxt = IDLE;
                        burst_nxt = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = OFF;
                        burst_nxt = burst + Cbit'(1);
                    end
                end
            end
            OFF: begin
                if (tick_tc) begin
                    state_nxt = ON;
                    tick_clr  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                burst_nxt = '0;
                tick_clr  = 1'b1;
            end
        endcase
`ifdef PULSE_BURST_RETRIGGER_EN
        // A restart wins over a burst that would otherwise finish this cycle.
        if (trig && state != IDLE) begin
            state_nxt = ON;
            burst_nxt = '0;
            tick_clr  = 1'b1;
            done_nxt  = 1'b0;
        end
`endif
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            burst <= '0;
            out   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            burst <= burst_nxt;
            out   <= (state_nxt == ON);
            busy  <= (state_nxt != IDLE);
            done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Scoreboard bench for pulse_burst_gen: a timeline model predicts out/busy/done for every cycle.
// Honours PULSE_BURST_RETRIGGER_EN the same way the design does.
module tb_pulse_burst_gen;

    localparam int ON_T   = 4;
    localparam int OFF_T  = 3;
    localparam int NB     = 3;
    localparam int PERIOD = ON_T + OFF_T;
    localparam int TOTAL  = NB * ON_T + (NB - 1) * OFF_T;
`ifdef PULSE_BURST_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    typedef struct packed {
        logic out;
        logic busy;
        logic done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic trig = 1'b0;
    logic out, busy, done;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Model: a burst is a timeline of TOTAL cycles measured from its first ON cycle.
    bit m_active = 1'b0;
    int m_el = 0;
    bit m_done = 1'b0;

    pulse_burst_gen #(
        .Nbit(3), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .NBURST(NB), .Cbit(2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .trig (trig),
        .out  (out),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    function automatic exp_t model_now();
        exp_t e;
        e.busy = m_active;
        e.out  = m_active && ((m_el % PERIOD) < ON_T);
        e.done = m_done;
        return e;
    endfunction

    // Advance the model across one clock edge with the given inputs.
    function automatic void model_step(input bit t, input bit r);
        bit was_active;
        if (!r) begin
            m_active = 1'b0;
            m_el     = 0;
            m_done   = 1'b0;
            return;
        end
        was_active = m_active;
        m_done = 1'b0;
        if (was_active) begin
            m_el++;
            if (m_el == TOTAL) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
        if (t && (!was_active || RETRIG)) begin
            m_active = 1'b1;
            m_el     = 0;
            m_done   = 1'b0;
        end
    endfunction

    task automatic cycle(input bit t, input bit r);
        @(negedge clk);
        rst  = r;
        trig = t;
        model_step(t, r);
        exp_q.push_back(model_now());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1);
    endtask

    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic async_reset(input int hold);
        @(negedge clk);
        rst  = 1'b0;
        trig = 1'b0;
        #1;
        check("async_out", out, 1'b0);
        check("async_busy", busy, 1'b0);
        check("async_done", done, 1'b0);
        model_step(1'b0, 1'b0);
        exp_q.push_back(model_now());
        for (int i = 1; i < hold; i++) cycle(1'b0, 1'b0);
    endtask

    // Monitor: the DUT presents a fresh output each cycle; compare it with the oldest prediction.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("out", out, e.out);
            check("busy", busy, e.busy);
            check("done", done, e.done);
        end
    end

    initial begin
        int guard;
        #1;
        check("reset_out", out, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        idle(50);

        // Single burst, then a trigger exactly on the done cycle.
        cycle(1'b1, 1'b1);
        guard = 0;
        while (!m_done && guard < 100) begin
            cycle(1'b0, 1'b1);
            guard++;
        end
        check("done_reached", m_done, 1'b1);
        cycle(1'b1, 1'b1);
        idle(25);

        // Extra trigger in the first OFF gap.
        cycle(1'b1, 1'b1);
        idle(5);
        cycle(1'b1, 1'b1);
        idle(30);

        // Reset in the middle of the second pulse, then a fresh burst.
        cycle(1'b1, 1'b1);
        idle(8);
        async_reset(3);
        idle(2);
        cycle(1'b1, 1'b1);
        idle(25);

        // Random triggers with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset($urandom_range(1, 3));
            end else begin
                cycle($urandom_range(0, 7) == 0, 1'b1);
            end
        end
        idle(25);

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
